mmu_walk_arbiter: RTL and testbench

// - Shares one mmu (page-table walker) among NUM_PORTS TLB requesters; port 0 = I-TLB, port 1 = D-TLB.
// - Round-robin grant; latches the winner's walk request and holds it to the mmu until mmu_write_entry.
// - Steers the response (write_entry/is_fault/upper PA) to the owning TLB only.
// - Discards responses for owners that withdraw (flush) mid-walk.
// - Sits between the TLBs' mmu_interface.tlb side and the mmu's mmu_interface.mmu side; the CSR fields bypass it.

---
 rtl/mmu_walk_arbiter_if.sv | 64 ++++++
 rtl/mmu_walk_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mmu_walk_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_walk_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : mmu_walk_arbiter_if
// Brief     : Walk request/response bundle between NUM_PORTS TLB requesters,
//             the walk arbiter and the single page-table walker (mmu).
//             master = arbiter view, slave = environment view (TLBs + mmu).
// Revision  : 1.0 - initial release
// ============================================================================
interface mmu_walk_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    // TLB side
    logic [NUM_PORTS-1:0]    req_request;
    logic [NUM_PORTS-1:0]    req_execute;
    logic [NUM_PORTS-1:0]    req_rnw;
    logic [NUM_PORTS*32-1:0] req_virtual_address;
    logic [NUM_PORTS-1:0]    req_write_entry;
    logic [NUM_PORTS-1:0]    req_is_fault;
    logic [19:0]             req_upper_physical_address;

    // mmu side
    logic                    mmu_request;
    logic                    mmu_execute;
    logic                    mmu_rnw;
    logic [31:0]             mmu_virtual_address;
    logic                    mmu_write_entry;
    logic [19:0]             mmu_upper_physical_address;
    logic                    mmu_is_fault;

    modport master (
        input  req_request,
        input  req_execute,
        input  req_rnw,
        input  req_virtual_address,
        output req_write_entry,
        output req_is_fault,
        output req_upper_physical_address,
        output mmu_request,
        output mmu_execute,
        output mmu_rnw,
        output mmu_virtual_address,
        input  mmu_write_entry,
        input  mmu_upper_physical_address,
        input  mmu_is_fault
    );

    modport slave (
        output req_request,
        output req_execute,
        output req_rnw,
        output req_virtual_address,
        input  req_write_entry,
        input  req_is_fault,
        input  req_upper_physical_address,
        input  mmu_request,
        input  mmu_execute,
        input  mmu_rnw,
        input  mmu_virtual_address,
        output mmu_write_entry,
        output mmu_upper_physical_address,
        output mmu_is_fault
    );
endinterface
`default_nettype wire

// File: rtl/mmu_walk_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mmu_walk_arbiter
// Brief    : Round-robin arbiter sharing one page-table walker among
//            NUM_PORTS TLBs. Latches the winning walk request, holds it to
//            the mmu until its response, steers the response to the owner
//            and discards responses for owners that withdrew mid-walk.
// Options  : MMU_ARB_PERF_EN - saturating per-port walk counters and a
//            wait-cycle counter; when undefined the perf outputs read 0.
// Revision : 1.0 - initial release
// ============================================================================
module mmu_walk_arbiter #(
    parameter int NUM_PORTS    = 2,
    parameter int RR_RESET_PTR = 0,
    parameter int PERF_WIDTH   = 32
) (
    input  wire                              clk,
    input  wire                              rst,
    mmu_walk_arbiter_if.master               bus,
    output logic [NUM_PORTS*PERF_WIDTH-1:0]  perf_walks,
    output logic [PERF_WIDTH-1:0]            perf_wait_cycles
);

    localparam int c_owner_w = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int c_sum_w   = c_owner_w + 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_walk  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_owner_w-1:0] r_owner;
    logic [c_owner_w-1:0] r_rr_ptr;
    logic [31:0]          r_va;
    logic                 r_execute;
    logic                 r_rnw;

    logic [c_sum_w-1:0]   w_sum;
    logic [c_owner_w-1:0] w_grant_idx;
    logic                 w_grant_valid;
    logic [31:0]          w_grant_va;
    logic [c_owner_w-1:0] w_owner_next_ptr;
    logic                 w_owner_req;
    logic                 w_forward;
    logic                 w_done;

    assign w_owner_req      = bus.req_request[r_owner];
    assign w_owner_next_ptr = (r_owner == c_owner_w'(NUM_PORTS - 1)) ?
                              '0 : (r_owner + c_owner_w'(1));

    // Round-robin search: first requesting port at or above rr_ptr, wrapping.
    // Iterating from the farthest offset down leaves the nearest hit last.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_sum         = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + c_sum_w'(k);
            if (w_sum >= c_sum_w'(NUM_PORTS)) begin
                w_sum = w_sum - c_sum_w'(NUM_PORTS);
            end
            if (bus.req_request[w_sum[c_owner_w-1:0]]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_sum[c_owner_w-1:0];
            end
        end
    end

    // Select the winner's virtual address for latching.
    always_comb begin
        w_grant_va = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_grant_idx == c_owner_w'(p)) begin
                w_grant_va = bus.req_virtual_address[p*32 +: 32];
            end
        end
    end

    // Next-state logic; a response in WALK is forwarded only if the owner
    // is still asking for it, a response in DRAIN is always swallowed.
    always_comb begin
        w_state_nxt = r_state;
        w_forward   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_grant_valid) begin
                    w_state_nxt = c_st_walk;
                end
            end
            c_st_walk: begin
                if (bus.mmu_write_entry) begin
                    w_done      = 1'b1;
                    w_forward   = w_owner_req;
                    w_state_nxt = c_st_idle;
                end else if (!w_owner_req) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if (bus.mmu_write_entry) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Response steering: only the owner sees the pulse; fault/PPN are zero otherwise.
    always_comb begin
        bus.req_write_entry            = '0;
        bus.req_is_fault               = '0;
        bus.req_upper_physical_address = '0;
        if (w_forward) begin
            bus.req_write_entry[r_owner]   = 1'b1;
            bus.req_is_fault[r_owner]      = bus.mmu_is_fault;
            bus.req_upper_physical_address = bus.mmu_upper_physical_address;
        end
    end

    assign bus.mmu_request         = (r_state != c_st_idle);
    assign bus.mmu_execute         = r_execute;
    assign bus.mmu_rnw             = r_rnw;
    assign bus.mmu_virtual_address = r_va;

    // State, owner, pointer and latched request; mmu outputs come only from here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_st_idle;
            r_owner   <= '0;
            r_rr_ptr  <= c_owner_w'(RR_RESET_PTR);
            r_va      <= '0;
            r_execute <= 1'b0;
            r_rnw     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_st_idle) && w_grant_valid) begin
                r_owner   <= w_grant_idx;
                r_va      <= w_grant_va;
                r_execute <= bus.req_execute[w_grant_idx];
                r_rnw     <= bus.req_rnw[w_grant_idx];
            end
            if (w_done) begin
                r_rr_ptr <= w_owner_next_ptr;
            end
        end
    end

`ifdef MMU_ARB_PERF_EN
    localparam logic [PERF_WIDTH-1:0] c_perf_max = '1;

    logic [NUM_PORTS-1:0] w_owner_mask;
    logic                 w_waiting;
    logic [PERF_WIDTH-1:0] r_wait_cycles;

    // A requester is waiting unless it is the owner of an active (non-drained) walk.
    always_comb begin
        w_owner_mask = '0;
        if (r_state == c_st_walk) begin
            w_owner_mask[r_owner] = 1'b1;
        end
        w_waiting = |(bus.req_request & ~w_owner_mask);
    end

    // Saturating wait-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait_cycles <= '0;
        end else if (w_waiting && (r_wait_cycles != c_perf_max)) begin
            r_wait_cycles <= r_wait_cycles + PERF_WIDTH'(1);
        end
    end

    assign perf_wait_cycles = r_wait_cycles;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_perf_walks
        logic [PERF_WIDTH-1:0] r_walks;

        // Saturating count of responses forwarded to this port.
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_walks <= '0;
            end else if (bus.req_write_entry[p] && (r_walks != c_perf_max)) begin
                r_walks <= r_walks + PERF_WIDTH'(1);
            end
        end

        assign perf_walks[p*PERF_WIDTH +: PERF_WIDTH] = r_walks;
    end
`else
    assign perf_walks       = '0;
    assign perf_wait_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmu_walk_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmu_walk_arbiter
// Brief    : Self-checking bench for mmu_walk_arbiter (2 ports): directed
//            scenarios plus a randomized run against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmu_walk_arbiter;
    localparam int NP = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*32-1:0]  perf_walks;
    logic [31:0]       perf_wait_cycles;
    int                n_cmp = 0;
    int                n_err = 0;

    mmu_walk_arbiter_if #(.NUM_PORTS(NP)) bus ();

    mmu_walk_arbiter #(
        .NUM_PORTS    (NP),
        .RR_RESET_PTR (0),
        .PERF_WIDTH   (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .perf_walks       (perf_walks),
        .perf_wait_cycles (perf_wait_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req_request                = '0;
        bus.req_execute                = '0;
        bus.req_rnw                    = '0;
        bus.req_virtual_address        = '0;
        bus.mmu_write_entry            = 1'b0;
        bus.mmu_is_fault               = 1'b0;
        bus.mmu_upper_physical_address = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive_idle();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        bus.req_request         = 2'b11;
        bus.req_rnw             = 2'b11;
        bus.req_virtual_address = {32'h2222_0000, 32'h1111_0000};
        tick();
        tick();
        n_cmp++; if (bus.mmu_request !== 1'b0) begin n_err++; $display("FAIL reset_mmu_request: got %b want 0", bus.mmu_request); end
        n_cmp++; if (bus.mmu_virtual_address !== 32'h0) begin n_err++; $display("FAIL reset_va: got %h want 0", bus.mmu_virtual_address); end
        n_cmp++; if ({bus.mmu_execute, bus.mmu_rnw} !== 2'b00) begin n_err++; $display("FAIL reset_attr: got %b want 00", {bus.mmu_execute, bus.mmu_rnw}); end
        n_cmp++; if ({bus.req_write_entry, bus.req_is_fault, bus.req_upper_physical_address} !== 24'h0) begin n_err++; $display("FAIL reset_resp: got %h want 0", {bus.req_write_entry, bus.req_is_fault, bus.req_upper_physical_address}); end
        n_cmp++; if ({perf_walks, perf_wait_cycles} !== 96'h0) begin n_err++; $display("FAIL reset_perf: got %h want 0", {perf_walks, perf_wait_cycles}); end
        rst = 1'b1;
        tick();
        n_cmp++; if ({bus.mmu_request, bus.mmu_virtual_address} !== {1'b1, 32'h1111_0000}) begin n_err++; $display("FAIL reset_first_grant: got %b/%h want 1/11110000", bus.mmu_request, bus.mmu_virtual_address); end
        bus.mmu_write_entry            = 1'b1;
        bus.mmu_upper_physical_address = 20'h0F0F0;
        #1;
        n_cmp++; if (bus.req_write_entry !== 2'b01) begin n_err++; $display("FAIL reset_first_resp: got %b want 01", bus.req_write_entry); end
        tick();
        bus.mmu_write_entry = 1'b0;
    endtask

    task automatic test_single_walk();
        logic [NP*32-1:0] exp_walks;
        do_reset();
        bus.req_request                 = 2'b10;
        bus.req_rnw                     = 2'b10;
        bus.req_virtual_address[63:32]  = 32'h8000_1000;
        bus.req_virtual_address[31:0]   = 32'hDEAD_0000;
        #1;
        n_cmp++; if (bus.mmu_request !== 1'b0) begin n_err++; $display("FAIL single_latency: got %b want 0", bus.mmu_request); end
        tick();
        n_cmp++; if ({bus.mmu_request, bus.mmu_virtual_address} !== {1'b1, 32'h8000_1000}) begin n_err++; $display("FAIL single_grant: got %b/%h want 1/80001000", bus.mmu_request, bus.mmu_virtual_address); end
        n_cmp++; if ({bus.mmu_execute, bus.mmu_rnw} !== 2'b01) begin n_err++; $display("FAIL single_attr: got %b want 01", {bus.mmu_execute, bus.mmu_rnw}); end
        tick();
        n_cmp++; if ({bus.mmu_request, bus.req_write_entry} !== 3'b100) begin n_err++; $display("FAIL single_hold: got %b want 100", {bus.mmu_request, bus.req_write_entry}); end
        bus.mmu_write_entry            = 1'b1;
        bus.mmu_upper_physical_address = 20'h12345;
        #1;
        n_cmp++; if ({bus.req_write_entry, bus.req_is_fault, bus.req_upper_physical_address} !== {2'b10, 2'b00, 20'h12345}) begin n_err++; $display("FAIL single_resp: got %b/%b/%h want 10/00/12345", bus.req_write_entry, bus.req_is_fault, bus.req_upper_physical_address); end
        tick();
        bus.mmu_write_entry = 1'b0;
        bus.req_request     = 2'b00;
        #1;
        n_cmp++; if ({bus.mmu_request, bus.req_write_entry, bus.req_upper_physical_address} !== 23'h0) begin n_err++; $display("FAIL single_release: got %b/%b/%h want 0/00/00000", bus.mmu_request, bus.req_write_entry, bus.req_upper_physical_address); end
`ifdef MMU_ARB_PERF_EN
        exp_walks = {32'd1, 32'd0};
`else
        exp_walks = '0;
`endif
        n_cmp++; if (perf_walks !== exp_walks) begin n_err++; $display("FAIL single_perf_walks: got %h want %h", perf_walks, exp_walks); end
    endtask

    task automatic test_contention();
        logic [31:0]      va [NP];
        int               n_edges;
        int               lat;
        logic [NP*32-1:0] exp_walks;
        logic [31:0]      exp_wait;
        do_reset();
        va[0] = 32'h1000_0000 | 32'($urandom_range(0, 16'hFFFF));
        va[1] = 32'h2000_0000 | 32'($urandom_range(0, 16'hFFFF));
        bus.req_request         = 2'b11;
        bus.req_virtual_address = {va[1], va[0]};
        n_edges = 0;
        for (int w = 0; w < 4; w++) begin
            tick(); n_edges++;
            n_cmp++; if ({bus.mmu_request, bus.mmu_virtual_address} !== {1'b1, va[w % 2]}) begin n_err++; $display("FAIL contention_grant%0d: got %b/%h want 1/%h", w, bus.mmu_request, bus.mmu_virtual_address, va[w % 2]); end
            lat = $urandom_range(0, 3);
            for (int i = 0; i < lat; i++) begin
                tick(); n_edges++;
            end
            bus.mmu_write_entry            = 1'b1;
            bus.mmu_upper_physical_address = 20'($urandom);
            #1;
            n_cmp++; if (bus.req_write_entry !== NP'(1 << (w % 2))) begin n_err++; $display("FAIL contention_resp%0d: got %b want %b", w, bus.req_write_entry, NP'(1 << (w % 2))); end
            tick(); n_edges++;
            bus.mmu_write_entry = 1'b0;
            n_cmp++; if (bus.mmu_request !== 1'b0) begin n_err++; $display("FAIL contention_gap%0d: got %b want 0", w, bus.mmu_request); end
        end
`ifdef MMU_ARB_PERF_EN
        exp_walks = {32'd2, 32'd2};
        exp_wait  = 32'(n_edges);
`else
        exp_walks = '0;
        exp_wait  = '0;
`endif
        n_cmp++; if (perf_walks !== exp_walks) begin n_err++; $display("FAIL contention_perf_walks: got %h want %h", perf_walks, exp_walks); end
        n_cmp++; if (perf_wait_cycles !== exp_wait) begin n_err++; $display("FAIL contention_perf_wait: got %0d want %0d", perf_wait_cycles, exp_wait); end
        bus.req_request = 2'b00;
    endtask

    task automatic test_withdraw();
        do_reset();
        bus.req_request         = 2'b10;
        bus.req_virtual_address = {32'hC0DE_1000, 32'hA0A0_2000};
        tick();
        n_cmp++; if ({bus.mmu_request, bus.mmu_virtual_address} !== {1'b1, 32'hC0DE_1000}) begin n_err++; $display("FAIL withdraw_grant: got %b/%h want 1/c0de1000", bus.mmu_request, bus.mmu_virtual_address); end
        bus.req_request = 2'b11;
        tick();
        tick();
        tick();
        bus.req_request = 2'b01;
        tick();
        n_cmp++; if (bus.mmu_request !== 1'b1) begin n_err++; $display("FAIL withdraw_drain_hold: got %b want 1", bus.mmu_request); end
        bus.req_request = 2'b11;
        tick();
        n_cmp++; if ({bus.mmu_request, bus.mmu_virtual_address} !== {1'b1, 32'hC0DE_1000}) begin n_err++; $display("FAIL withdraw_drain_stable: got %b/%h want 1/c0de1000", bus.mmu_request, bus.mmu_virtual_address); end
        bus.mmu_write_entry            = 1'b1;
        bus.mmu_upper_physical_address = 20'h55555;
        #1;
        n_cmp++; if ({bus.req_write_entry, bus.req_upper_physical_address} !== 22'h0) begin n_err++; $display("FAIL withdraw_drop: got %b/%h want 00/00000", bus.req_write_entry, bus.req_upper_physical_address); end
        tick();
        bus.mmu_write_entry = 1'b0;
        n_cmp++; if (bus.mmu_request !== 1'b0) begin n_err++; $display("FAIL withdraw_release: got %b want 0", bus.mmu_request); end
        tick();
        n_cmp++; if ({bus.mmu_request, bus.mmu_virtual_address} !== {1'b1, 32'hA0A0_2000}) begin n_err++; $display("FAIL withdraw_next_grant: got %b/%h want 1/a0a02000", bus.mmu_request, bus.mmu_virtual_address); end
        bus.req_request     = 2'b10;
        bus.mmu_write_entry = 1'b1;
        #1;
        n_cmp++; if (bus.req_write_entry !== 2'b00) begin n_err++; $display("FAIL withdraw_same_cycle: got %b want 00", bus.req_write_entry); end
        tick();
        bus.mmu_write_entry = 1'b0;
        bus.req_request     = 2'b11;
        tick();
        n_cmp++; if (bus.mmu_virtual_address !== 32'hC0DE_1000) begin n_err++; $display("FAIL withdraw_ptr_advance: got %h want c0de1000", bus.mmu_virtual_address); end
        bus.req_request = 2'b00;
    endtask

    task automatic test_fault();
        do_reset();
        bus.req_request         = 2'b01;
        bus.req_execute         = 2'b01;
        bus.req_rnw             = 2'b01;
        bus.req_virtual_address = {32'h0, 32'h0040_0000};
        tick();
        n_cmp++; if ({bus.mmu_execute, bus.mmu_rnw} !== 2'b11) begin n_err++; $display("FAIL fault_attr: got %b want 11", {bus.mmu_execute, bus.mmu_rnw}); end
        bus.mmu_write_entry            = 1'b1;
        bus.mmu_is_fault               = 1'b1;
        bus.mmu_upper_physical_address = 20'hABCDE;
        #1;
        n_cmp++; if ({bus.req_write_entry, bus.req_is_fault} !== 4'b0101) begin n_err++; $display("FAIL fault_resp: got %b/%b want 01/01", bus.req_write_entry, bus.req_is_fault); end
        tick();
        bus.mmu_write_entry = 1'b0;
        bus.req_request     = 2'b00;
        #1;
        n_cmp++; if ({bus.req_is_fault, bus.req_upper_physical_address} !== 22'h0) begin n_err++; $display("FAIL fault_idle_zero: got %b/%h want 00/00000", bus.req_is_fault, bus.req_upper_physical_address); end
    endtask

    task automatic test_midwalk_reset();
        do_reset();
        bus.req_request         = 2'b01;
        bus.req_virtual_address = {32'h0, 32'h0000_7000};
        tick();
        n_cmp++; if (bus.mmu_request !== 1'b1) begin n_err++; $display("FAIL midreset_walk: got %b want 1", bus.mmu_request); end
        rst = 1'b0;
        tick();
        n_cmp++; if ({bus.mmu_request, bus.mmu_virtual_address} !== 33'h0) begin n_err++; $display("FAIL midreset_abort: got %b/%h want 0/0", bus.mmu_request, bus.mmu_virtual_address); end
        rst                            = 1'b1;
        bus.req_request                = 2'b00;
        bus.mmu_write_entry            = 1'b1;
        bus.mmu_upper_physical_address = 20'h77777;
        #1;
        n_cmp++; if ({bus.req_write_entry, bus.req_upper_physical_address} !== 22'h0) begin n_err++; $display("FAIL midreset_stray: got %b/%h want 00/00000", bus.req_write_entry, bus.req_upper_physical_address); end
        tick();
        bus.mmu_write_entry = 1'b0;
        n_cmp++; if (bus.mmu_request !== 1'b0) begin n_err++; $display("FAIL midreset_idle: got %b want 0", bus.mmu_request); end
    endtask

    // Randomized traffic against a walk-level model: who owns the walker,
    // whether the owner has given up, and where the round-robin search starts.
    task automatic test_random();
        int               m_owner;
        bit               m_drain;
        int               m_ptr;
        logic [31:0]      m_va;
        logic             m_exe;
        logic             m_rnw;
        int               m_walks [NP];
        int               m_wait;
        logic [NP-1:0]    exp_we;
        logic [NP-1:0]    exp_flt;
        logic [19:0]      exp_ppn;
        logic [NP*32-1:0] exp_pw;
        logic [31:0]      exp_pwait;
        bit               waiting;
        int               cand;
        do_reset();
        m_owner = -1; m_drain = 1'b0; m_ptr = 0;
        m_va = '0; m_exe = 1'b0; m_rnw = 1'b0;
        m_walks = '{default: 0}; m_wait = 0;
        exp_we = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < NP; p++) begin
                if (exp_we[p]) bus.req_request[p] = 1'b0;
                else if (bus.req_request[p]) begin
                    if ($urandom_range(0, 24) == 0) bus.req_request[p] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) bus.req_request[p] = 1'b1;
                bus.req_virtual_address[p*32 +: 32] = $urandom;
                bus.req_execute[p] = 1'($urandom_range(0, 1));
                bus.req_rnw[p]     = 1'($urandom_range(0, 1));
            end
            bus.mmu_write_entry            = (m_owner >= 0) && ($urandom_range(0, 3) == 0);
            bus.mmu_is_fault               = 1'($urandom_range(0, 1));
            bus.mmu_upper_physical_address = 20'($urandom);
            #1;
            exp_we = '0; exp_flt = '0; exp_ppn = '0;
            if (m_owner >= 0 && !m_drain && bus.mmu_write_entry && bus.req_request[m_owner]) begin
                exp_we[m_owner]  = 1'b1;
                exp_flt[m_owner] = bus.mmu_is_fault;
                exp_ppn          = bus.mmu_upper_physical_address;
            end
            n_cmp++; if (bus.mmu_request !== (m_owner >= 0)) begin n_err++; $display("FAIL rand_mmu_request c%0d: got %b want %b", cyc, bus.mmu_request, (m_owner >= 0)); end
            n_cmp++; if (bus.mmu_virtual_address !== m_va) begin n_err++; $display("FAIL rand_va c%0d: got %h want %h", cyc, bus.mmu_virtual_address, m_va); end
            n_cmp++; if ({bus.mmu_execute, bus.mmu_rnw} !== {m_exe, m_rnw}) begin n_err++; $display("FAIL rand_attr c%0d: got %b want %b", cyc, {bus.mmu_execute, bus.mmu_rnw}, {m_exe, m_rnw}); end
            n_cmp++; if (bus.req_write_entry !== exp_we) begin n_err++; $display("FAIL rand_write_entry c%0d: got %b want %b", cyc, bus.req_write_entry, exp_we); end
            n_cmp++; if (bus.req_is_fault !== exp_flt) begin n_err++; $display("FAIL rand_is_fault c%0d: got %b want %b", cyc, bus.req_is_fault, exp_flt); end
            n_cmp++; if (bus.req_upper_physical_address !== exp_ppn) begin n_err++; $display("FAIL rand_ppn c%0d: got %h want %h", cyc, bus.req_upper_physical_address, exp_ppn); end
`ifdef MMU_ARB_PERF_EN
            exp_pw    = {32'(m_walks[1]), 32'(m_walks[0])};
            exp_pwait = 32'(m_wait);
`else
            exp_pw    = '0;
            exp_pwait = '0;
`endif
            n_cmp++; if ({perf_walks, perf_wait_cycles} !== {exp_pw, exp_pwait}) begin n_err++; $display("FAIL rand_perf c%0d: got %h/%0d want %h/%0d", cyc, perf_walks, perf_wait_cycles, exp_pw, exp_pwait); end
            waiting = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (bus.req_request[p] && !(m_owner == p && !m_drain)) waiting = 1'b1;
            end
            if (waiting) m_wait++;
            if (exp_we != '0) m_walks[m_owner]++;
            if (m_owner < 0) begin
                for (int k = 0; k < NP; k++) begin
                    cand = (m_ptr + k) % NP;
                    if (m_owner < 0 && bus.req_request[cand]) begin
                        m_owner = cand;
                        m_drain = 1'b0;
                        m_va    = bus.req_virtual_address[cand*32 +: 32];
                        m_exe   = bus.req_execute[cand];
                        m_rnw   = bus.req_rnw[cand];
                    end
                end
            end else if (bus.mmu_write_entry) begin
                m_ptr   = (m_owner + 1) % NP;
                m_owner = -1;
                m_drain = 1'b0;
            end else if (!m_drain && !bus.req_request[m_owner]) begin
                m_drain = 1'b1;
            end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rst = 1'b0;
        test_reset();
        test_single_walk();
        test_contention();
        test_withdraw();
        test_fault();
        test_midwalk_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
